// File: rtl/rand_start_timer.sv
// Random start-delay timer: deserialises NBITS LFSR bits into a tick delay,
// counts it down, then pulses go; a press before go aborts with false_start.
module rand_start_timer #(
  parameter int NBITS     = 4,
  parameter int MIN_DELAY = 2,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          rbit,
  input  logic          start,
  input  logic          press,
  output logic          go,
  output logic          busy,
  output logic          false_start,
  output logic [CW-1:0] delay_val
);

  // Interface timing: tick, press, go and false_start are single-clk pulses
  // qualified only by being high on a rising edge; start is a level seen in IDLE.
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WAIT, S_GO} state_t;

  localparam int            BW    = $clog2(NBITS + 1);
  localparam logic [BW-1:0] LAST  = BW'(NBITS - 1);
  localparam logic [CW-1:0] MIN_D = CW'(MIN_DELAY);

  state_t           state, state_n;
  logic [NBITS-1:0] shreg, shreg_n, shifted;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [CW-1:0]    cnt, cnt_n, delay_n, loaded;
  logic             go_n, busy_n, fs_n;

  assign shifted = {shreg[NBITS-2:0], rbit};
  assign loaded  = MIN_D + CW'(shifted);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      delay_val   <= '0;
      go          <= 1'b0;
      busy        <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bitcnt      <= bitcnt_n;
      cnt         <= cnt_n;
      delay_val   <= delay_n;
      go          <= go_n;
      busy        <= busy_n;
      false_start <= fs_n;
    end
  end

  // Press outranks tick, so a coincident tick never shifts or decrements.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_COLLECT;
      S_COLLECT: begin
        if (press)                        state_n = S_IDLE;
        else if (tick && bitcnt == LAST)  state_n = S_WAIT;
      end
      S_WAIT: begin
        if (press)                        state_n = S_IDLE;
        else if (tick && cnt == CW'(1))   state_n = S_GO;
      end
      S_GO:      state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    cnt_n    = cnt;
    delay_n  = delay_val;
    go_n     = (state_n == S_GO);
    busy_n   = (state_n != S_IDLE);
    fs_n     = press && (state == S_COLLECT || state == S_WAIT);
    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_n  = '0;
          bitcnt_n = '0;
          cnt_n    = '0;
        end
      end
      S_COLLECT: begin
        if (press) begin
          shreg_n  = '0;
          bitcnt_n = '0;
          cnt_n    = '0;
        end else if (tick) begin
          shreg_n = shifted;
          if (bitcnt == LAST) begin
            bitcnt_n = '0;
            cnt_n    = loaded;
            delay_n  = loaded;
          end else begin
            bitcnt_n = bitcnt + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (press) begin
          shreg_n  = '0;
          bitcnt_n = '0;
          cnt_n    = '0;
        end else if (tick) begin
          cnt_n = (cnt == CW'(1)) ? '0 : cnt - 1'b1;
        end
      end
      S_GO: begin
        shreg_n  = '0;
        bitcnt_n = '0;
        cnt_n    = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rand_start_timer.sv
// Directed bench for rand_start_timer: driver tasks push expected go/false_start
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_rand_start_timer;
  localparam int CW = 6;
  localparam int W  = CW + 1;

  logic          clk = 1'b0;
  logic          rst, tick, rbit, start, press;
  logic          go, busy, false_start;
  logic [CW-1:0] delay_val;

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  rand_start_timer #(.NBITS(4), .MIN_DELAY(2), .CW(CW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rbit(rbit), .start(start),
    .press(press), .go(go), .busy(busy), .false_start(false_start),
    .delay_val(delay_val)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // scoreboard monitor: each event is {is_go, delay_val}
  always @(negedge clk) begin
    logic [W-1:0] got_ev;
    logic [W-1:0] want_ev;
    if (!rst && (go || false_start)) begin
      got_ev = {go, delay_val};
      check("pulse_exclusive", {31'd0, go & false_start}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got go=%0b fs=%0b delay=%0d want no pulse",
                 go, false_start, delay_val);
      end else begin
        want_ev = exp_q.pop_front();
        check("pulse_event", {25'd0, got_ev}, {25'd0, want_ev});
      end
    end
  end

  // driver tasks
  task automatic tick_once(input logic b, input logic p = 1'b0);
    @(negedge clk);
    tick = 1'b1; rbit = b; press = p;
    @(negedge clk);
    tick = 1'b0; rbit = 1'b0; press = 1'b0;
  endtask

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic collect(input logic [3:0] bits, input int exp_d);
    for (int i = 3; i >= 0; i--) tick_once(bits[i]);
    check("delay_val", {26'd0, delay_val}, exp_d);
    check("busy_in_wait", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_go(input int n, input int exp_d, input int gap);
    for (int i = 1; i <= n; i++) begin
      if (i == n) exp_q.push_back({1'b1, CW'(exp_d)});
      tick_once(1'b0);
      if (i < n) begin
        check("no_early_go", {31'd0, go}, 32'd0);
        repeat (gap) @(negedge clk);
      end else begin
        check("go_on_last_tick", {31'd0, go}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; rbit = 1'b0; start = 1'b0; press = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", {31'd0, go}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fs", {31'd0, false_start}, 32'd0);
    check("rst_delay", {26'd0, delay_val}, 32'd0);
    rst = 1'b0;

    // 1011 -> 13, with a stray start mid-wait and gaps between ticks
    do_start();
    collect(4'b1011, 13);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_go(13, 13, 1);
    @(negedge clk);
    check("go_one_clk", {31'd0, go}, 32'd0);
    check("busy_after_go", {31'd0, busy}, 32'd0);

    // 0000 -> 2, press while go is high
    do_start();
    collect(4'b0000, 2);
    wait_go(2, 2, 0);
    press = 1'b1;
    @(negedge clk); press = 1'b0;
    check("press_at_go_fs", {31'd0, false_start}, 32'd0);
    check("press_at_go_busy", {31'd0, busy}, 32'd0);

    // 1111 -> 17
    do_start();
    collect(4'b1111, 17);
    wait_go(17, 17, 0);

    // false start after 5 wait ticks
    do_start();
    collect(4'b1011, 13);
    repeat (5) tick_once(1'b0);
    @(negedge clk);
    exp_q.push_back({1'b0, CW'(13)});
    press = 1'b1;
    @(negedge clk); press = 1'b0;
    check("fs_pulse", {31'd0, false_start}, 32'd1);
    check("fs_busy", {31'd0, busy}, 32'd0);
    check("fs_delay_hold", {26'd0, delay_val}, 32'd13);
    @(negedge clk);
    check("fs_one_clk", {31'd0, false_start}, 32'd0);
    repeat (16) tick_once(1'b0);

    // press coincident with a tick
    do_start();
    collect(4'b1011, 13);
    repeat (5) tick_once(1'b0);
    exp_q.push_back({1'b0, CW'(13)});
    tick_once(1'b0, 1'b1);
    check("fs_tick_pulse", {31'd0, false_start}, 32'd1);
    check("fs_tick_busy", {31'd0, busy}, 32'd0);

    // press in IDLE
    @(negedge clk); press = 1'b1;
    @(negedge clk); press = 1'b0;
    check("idle_press_fs", {31'd0, false_start}, 32'd0);

    // async reset mid-WAIT
    do_start();
    collect(4'b1011, 13);
    repeat (3) tick_once(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_go", {31'd0, go}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_delay", {26'd0, delay_val}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) tick_once(1'b0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // start held: back-to-back rounds with fresh bits
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    check("held_busy_1", {31'd0, busy}, 32'd1);
    collect(4'b0100, 6);
    wait_go(6, 6, 0);
    @(negedge clk);
    check("held_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("held_restart", {31'd0, busy}, 32'd1);
    collect(4'b0011, 5);
    wait_go(5, 5, 0);
    start = 1'b0;
    @(negedge clk);
    check("held_end_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("stays_idle", {31'd0, busy}, 32'd0);

    // final report
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
